// File: rtl/fc_mem_responder.sv
// Memory-side responder for the FC data loader: single-beat read/write requests serviced on a synchronous SRAM port.
// Optional build macro FC_MEM_RANGE_CHK_EN: drop out-of-range requests and raise a sticky err flag.
module fc_mem_responder #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RACK} state_t;

  state_t     state;
  logic [2:0] cnt;

`ifdef FC_MEM_RANGE_CHK_EN
  logic wr_oor;
  logic rd_oor_now;
  logic rd_oor;

  assign wr_oor     = |waddr[ADDR_W-1:MEM_AW];
  assign rd_oor_now = |raddr[ADDR_W-1:MEM_AW];
`else
  logic unused_upper_bits;

  assign unused_upper_bits = ^{waddr[ADDR_W-1:MEM_AW], raddr[ADDR_W-1:MEM_AW]};
  assign err = 1'b0;
`endif

  // Capture happens one cycle after the SRAM data first appears, giving an ack RD_LAT+1 cycles after the request edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      wready    <= 1'b0;
      rready    <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
`ifdef FC_MEM_RANGE_CHK_EN
      rd_oor    <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      wready <= 1'b0;
      rready <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wvalid) begin
`ifdef FC_MEM_RANGE_CHK_EN
            mem_cs <= !wr_oor;
            mem_we <= !wr_oor;
            if (wr_oor) err <= 1'b1;
`else
            mem_cs <= 1'b1;
            mem_we <= 1'b1;
`endif
            mem_addr  <= waddr[MEM_AW-1:0];
            mem_wdata <= wdata;
            state     <= S_WR;
          end else if (rvalid) begin
`ifdef FC_MEM_RANGE_CHK_EN
            mem_cs <= !rd_oor_now;
            rd_oor <= rd_oor_now;
            if (rd_oor_now) err <= 1'b1;
`else
            mem_cs <= 1'b1;
`endif
            mem_addr <= raddr[MEM_AW-1:0];
            cnt      <= 3'(RD_LAT);
            state    <= S_RD;
          end
        end
        S_WR: begin
          wready <= 1'b1;
          state  <= S_IDLE;
        end
        S_RD: begin
          if (cnt == 3'd0) begin
`ifdef FC_MEM_RANGE_CHK_EN
            rdata <= rd_oor ? '0 : mem_rdata;
`else
            rdata <= mem_rdata;
`endif
            rready <= 1'b1;
            state  <= S_RACK;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mem_responder.sv
// Directed, table-driven bench for fc_mem_responder with a behavioural RD_LAT-cycle SRAM model.
module tb_fc_mem_responder;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [ADDR_W-1:0] raddr = '0;
  logic [DATA_W-1:0] rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;
  int cs_count = 0;
  int rready_count = 0;
  int wready_count = 0;

  fc_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // SRAM model: read data is valid only in the single cycle RD_LAT edges after the chip select.
  logic [DATA_W-1:0] sram [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_cs && !mem_we) ? sram[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_cs) cs_count <= cs_count + 1;
    if (rready) rready_count <= rready_count + 1;
    if (wready) wready_count <= wready_count + 1;
  end

  typedef struct {
    bit                is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int lat);
    wvalid = 1'b1; waddr = a; wdata = d; lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (wready) begin lat = k; break; end
    end
    wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output int lat);
    rvalid = 1'b1; raddr = a; lat = -1; d = 'x;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rready) begin lat = k; d = rdata; break; end
    end
    rvalid = 1'b0;
  endtask

  // One transaction plus the following cycle, in which the ack must already be gone.
  task automatic applyStimulus(input vec_t v, input string name);
    int lat;
    int cs0;
    logic [DATA_W-1:0] d;
    cs0 = cs_count;
    if (v.is_write) begin
      do_write(v.addr, v.data, lat);
      checkOutput({name, "_wr_lat"}, 64'(lat), 64'(1));
      @(posedge clk); #1;
      checkOutput({name, "_wready_pulse"}, 64'(wready), 64'(0));
    end else begin
      do_read(v.addr, d, lat);
      checkOutput({name, "_rd_lat"}, 64'(lat), 64'(RD_LAT + 1));
      checkOutput({name, "_rdata"}, 64'(d), 64'(v.data));
      @(posedge clk); #1;
      checkOutput({name, "_rready_pulse"}, 64'(rready), 64'(0));
    end
    checkOutput({name, "_cs_count"}, 64'(cs_count - cs0), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, wk, rk, cs0, rc0, bad_data, bad_lat, bad_pulse;
    logic [DATA_W-1:0] d;

    vecs[0] = '{1'b1, 26'h10,   32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 26'h10,   32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 26'h3FF,  32'h0000_0001};
    vecs[3] = '{1'b1, 26'hFFFF, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 26'hFFFF, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 26'h3FF,  32'h0000_0001};
    vecs[6] = '{1'b1, 26'h10,   32'h5555_AAAA};
    vecs[7] = '{1'b0, 26'h10,   32'h5555_AAAA};
    vecs[8] = '{1'b1, 26'h0,    32'h0000_0000};
    vecs[9] = '{1'b0, 26'h0,    32'h0000_0000};

    #1;
    checkOutput("reset_ctrl", 64'({wready, rready, mem_cs, mem_we, err}), 64'(0));
    checkOutput("reset_addr", 64'(mem_addr), 64'(0));
    checkOutput("reset_data", {mem_wdata, rdata}, 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
    // Re-read a non-zero location so rdata is non-zero before the next corner cases.
    applyStimulus('{1'b0, 26'h10, 32'h5555_AAAA}, "reread");

    // Simultaneous requests: write first, read sampled right after the write ack.
    wvalid = 1'b1; rvalid = 1'b1; waddr = 26'h20; raddr = 26'h20; wdata = 32'h1234;
    wk = -1; rk = -1; d = 'x;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (wready && wk < 0) begin wk = k; wvalid = 1'b0; end
      if (rready) begin rk = k; d = rdata; break; end
    end
    rvalid = 1'b0;
    checkOutput("simul_wr_lat", 64'(wk), 64'(1));
    checkOutput("simul_rd_lat", 64'(rk), 64'(RD_LAT + 3));
    checkOutput("simul_rdata", 64'(d), 64'h1234);
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) begin
      do_write(26'h100 + 26'(i), {16'hC0DE, 16'(i * 3)}, lat);
      @(posedge clk); #1;
    end
    cs0 = cs_count; rc0 = rready_count;
    bad_data = 0; bad_lat = 0; bad_pulse = 0;
    for (int i = 0; i < 64; i++) begin
      do_read(26'h100 + 26'(i), d, lat);
      if (d !== {16'hC0DE, 16'(i * 3)}) bad_data++;
      if (lat != RD_LAT + 1) bad_lat++;
      @(posedge clk); #1;
      if (rready !== 1'b0) bad_pulse++;
    end
    checkOutput("seq64_data_errs", 64'(bad_data), 64'(0));
    checkOutput("seq64_lat_errs", 64'(bad_lat), 64'(0));
    checkOutput("seq64_pulse_errs", 64'(bad_pulse), 64'(0));
    checkOutput("seq64_rready_count", 64'(rready_count - rc0), 64'(64));
    checkOutput("seq64_cs_count", 64'(cs_count - cs0), 64'(64));

    applyStimulus('{1'b0, 26'h10, 32'h5555_AAAA}, "pre_reset_read");
    rvalid = 1'b1; raddr = 26'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 64'({wready, rready, mem_cs, mem_we, err}), 64'(0));
    checkOutput("midrst_addr", 64'(mem_addr), 64'(0));
    checkOutput("midrst_data", {mem_wdata, rdata}, 64'(0));
    rvalid = 1'b0;
    rc0 = rready_count;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_ack", 64'(rready_count - rc0), 64'(0));
    applyStimulus('{1'b0, 26'h10, 32'h5555_AAAA}, "post_reset_read");

`ifdef FC_MEM_RANGE_CHK_EN
    checkOutput("oor_err_before", 64'(err), 64'(0));
    cs0 = cs_count;
    do_read(26'h10000, d, lat);
    checkOutput("oor_rd_lat", 64'(lat), 64'(RD_LAT + 1));
    checkOutput("oor_rdata", 64'(d), 64'(0));
    checkOutput("oor_no_cs", 64'(cs_count - cs0), 64'(0));
    checkOutput("oor_err_set", 64'(err), 64'(1));
    @(posedge clk); #1;
    applyStimulus('{1'b0, 26'h10, 32'h5555_AAAA}, "oor_then_legal");
    checkOutput("oor_err_sticky", 64'(err), 64'(1));
`else
    applyStimulus('{1'b1, 26'h10005, 32'h0000_00A5}, "wrap_write");
    applyStimulus('{1'b0, 26'h5, 32'h0000_00A5}, "wrap_read_low");
    applyStimulus('{1'b0, 26'h3FF_0005, 32'h0000_00A5}, "wrap_read_high");
    checkOutput("wrap_err_zero", 64'(err), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
